// File: rtl/control_pipe.sv
// Decodes RV32I (+ optional MUL/DIV) opcodes into a control word registered into the ID/EX stage.
// Latency: one cycle from ID accept to EX valid; MUL/DIV holds EX for MUL_LAT cycles.
// Backpressure: ID stalls on ex_ready low, MUL/DIV busy or load-use hazard; flush always consumes ID.
module control_pipe #(
    parameter bit          MULDIV_EN = 1'b1,
    parameter int unsigned MUL_LAT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic [6:0] op,
    input  logic       funct7_0,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    input  logic       flush,
    input  logic       ex_ready,
    output logic       ex_valid,
    output logic [1:0] ex_ALU_op,
    output logic [1:0] ex_DMtoReg,
    output logic       ex_RegWrite,
    output logic       ex_DM_en,
    output logic       ex_DM_write,
    output logic       ex_jump,
    output logic       ex_jalr,
    output logic       ex_branch,
    output logic       ex_ALU_src,
    output logic       ex_auipc,
    output logic       ex_muldiv,
    output logic       ex_illegal,
    output logic [4:0] ex_rd,
    output logic       ex_busy
);

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] dmtoreg;
        logic       regwrite;
        logic       dm_en;
        logic       dm_write;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic       alu_src;
        logic       auipc;
        logic       muldiv;
        logic       illegal;
    } ctrl_t;

    // Word loaded on bubbles and reset; illegal instructions start from it too.
    localparam ctrl_t CTRL_DEFAULT = '{alu_op: 2'b11, dmtoreg: 2'b00, regwrite: 1'b0,
                                       dm_en: 1'b0, dm_write: 1'b0, jump: 1'b0, jalr: 1'b0,
                                       branch: 1'b0, alu_src: 1'b1, auipc: 1'b0,
                                       muldiv: 1'b0, illegal: 1'b0};
    localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

    ctrl_t      dec;
    ctrl_t      ex_q;
    logic       rs1_used;
    logic       rs2_used;
    logic       hazard;
    logic       adv;
    logic [3:0] cnt;

    // Opcode decode and source-register usage for the ID instruction.
    always_comb begin
        dec      = CTRL_DEFAULT;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (op)
            7'b0110011: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                if (funct7_0 && !MULDIV_EN) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.alu_op   = 2'b00;
                    dec.dmtoreg  = 2'b10;
                    dec.regwrite = 1'b1;
                    dec.alu_src  = 1'b0;
                    dec.muldiv   = funct7_0;
                end
            end
            7'b0010011: begin
                rs1_used     = 1'b1;
                dec.alu_op   = 2'b01;
                dec.dmtoreg  = 2'b10;
                dec.regwrite = 1'b1;
            end
            7'b0000011: begin
                rs1_used     = 1'b1;
                dec.alu_op   = 2'b10;
                dec.dmtoreg  = 2'b11;
                dec.regwrite = 1'b1;
                dec.dm_en    = 1'b1;
            end
            7'b0100011: begin
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                dec.alu_op   = 2'b10;
                dec.dm_en    = 1'b1;
                dec.dm_write = 1'b1;
            end
            7'b1100011: begin
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                dec.alu_op   = 2'b10;
                dec.branch   = 1'b1;
                dec.alu_src  = 1'b0;
            end
            7'b0110111: begin
                dec.regwrite = 1'b1;
            end
            7'b1101111: begin
                dec.dmtoreg  = 2'b01;
                dec.regwrite = 1'b1;
                dec.jump     = 1'b1;
            end
            7'b1100111: begin
                rs1_used     = 1'b1;
                dec.alu_op   = 2'b01;
                dec.dmtoreg  = 2'b01;
                dec.regwrite = 1'b1;
                dec.jump     = 1'b1;
                dec.jalr     = 1'b1;
            end
            7'b0010111: begin
                dec.alu_op   = 2'b01;
                dec.dmtoreg  = 2'b10;
                dec.regwrite = 1'b1;
                dec.auipc    = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign hazard = ex_valid && ex_q.dm_en && !ex_q.dm_write && (ex_rd != 5'd0) && id_valid &&
                    ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
    assign adv      = !ex_valid || (ex_ready && !ex_busy);
    assign id_ready = !rst && (flush || (adv && id_valid && !hazard));
    assign ex_busy  = (cnt != 4'd0);

    // ID/EX register: bubble or load on advance, otherwise hold and count down MUL/DIV latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= CTRL_DEFAULT;
            ex_valid <= 1'b0;
            ex_rd    <= 5'd0;
            cnt      <= 4'd0;
        end else if (adv) begin
            if (flush || hazard || !id_valid) begin
                ex_q     <= CTRL_DEFAULT;
                ex_valid <= 1'b0;
                ex_rd    <= 5'd0;
                cnt      <= 4'd0;
            end else begin
                ex_q     <= dec;
                ex_valid <= 1'b1;
                ex_rd    <= rd;
                cnt      <= dec.muldiv ? LAT_M1 : 4'd0;
            end
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign ex_ALU_op   = ex_q.alu_op;
    assign ex_DMtoReg  = ex_q.dmtoreg;
    assign ex_RegWrite = ex_q.regwrite;
    assign ex_DM_en    = ex_q.dm_en;
    assign ex_DM_write = ex_q.dm_write;
    assign ex_jump     = ex_q.jump;
    assign ex_jalr     = ex_q.jalr;
    assign ex_branch   = ex_q.branch;
    assign ex_ALU_src  = ex_q.alu_src;
    assign ex_auipc    = ex_q.auipc;
    assign ex_muldiv   = ex_q.muldiv;
    assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: directed scenarios plus randomized traffic against a reference model.
// Latency: model tracks EX contents one cycle behind ID acceptance.
// Backpressure: random ex_ready, flush and reset exercise stalls and drops.
module tb_control_pipe;

    localparam int MUL_LAT = 4;

    // Control word packing: alu(2) dm(2) rw dmen dmw jump jalr branch src auipc muldiv illegal
    localparam logic [13:0] W_DEF   = 14'b11_00_0000001000;
    localparam logic [13:0] W_R     = 14'b00_10_1000000000;
    localparam logic [13:0] W_MUL   = 14'b00_10_1000000010;
    localparam logic [13:0] W_I     = 14'b01_10_1000001000;
    localparam logic [13:0] W_LW    = 14'b10_11_1100001000;
    localparam logic [13:0] W_S     = 14'b10_00_0110001000;
    localparam logic [13:0] W_B     = 14'b10_00_0000010000;
    localparam logic [13:0] W_LUI   = 14'b11_00_1000001000;
    localparam logic [13:0] W_JAL   = 14'b11_01_1001001000;
    localparam logic [13:0] W_JALR  = 14'b01_01_1001101000;
    localparam logic [13:0] W_AUIPC = 14'b01_10_1000001100;
    localparam logic [13:0] W_ILL   = 14'b11_00_0000001001;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                           OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LUI = 7'b0110111,
                           OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic rst, id_valid, funct7_0, flush, ex_ready;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;

    logic       id_ready, ex_valid, ex_RegWrite, ex_DM_en, ex_DM_write, ex_jump, ex_jalr;
    logic       ex_branch, ex_ALU_src, ex_auipc, ex_muldiv, ex_illegal, ex_busy;
    logic [1:0] ex_ALU_op, ex_DMtoReg;
    logic [4:0] ex_rd;

    logic       d2_id_ready, d2_ex_valid, d2_RegWrite, d2_DM_en, d2_DM_write, d2_jump, d2_jalr;
    logic       d2_branch, d2_ALU_src, d2_auipc, d2_muldiv, d2_illegal, d2_busy;
    logic [1:0] d2_ALU_op, d2_DMtoReg;
    logic [4:0] d2_rd;

    int checks = 0;
    int errors = 0;

    // Reference model state: what EX holds and how many more cycles a MUL/DIV keeps it busy.
    bit          m_valid;
    logic [13:0] m_word;
    logic [4:0]  m_rd;
    int          m_hold;

    wire [13:0] dut_word = {ex_ALU_op, ex_DMtoReg, ex_RegWrite, ex_DM_en, ex_DM_write, ex_jump,
                            ex_jalr, ex_branch, ex_ALU_src, ex_auipc, ex_muldiv, ex_illegal};

    always #5 clk = ~clk;

    control_pipe #(.MULDIV_EN(1'b1), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .op(op),
        .funct7_0(funct7_0), .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_ALU_op(ex_ALU_op),
        .ex_DMtoReg(ex_DMtoReg), .ex_RegWrite(ex_RegWrite), .ex_DM_en(ex_DM_en),
        .ex_DM_write(ex_DM_write), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
        .ex_branch(ex_branch), .ex_ALU_src(ex_ALU_src), .ex_auipc(ex_auipc),
        .ex_muldiv(ex_muldiv), .ex_illegal(ex_illegal), .ex_rd(ex_rd), .ex_busy(ex_busy)
    );

    control_pipe #(.MULDIV_EN(1'b0), .MUL_LAT(MUL_LAT)) dut_nomd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(d2_id_ready), .op(op),
        .funct7_0(funct7_0), .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush),
        .ex_ready(ex_ready), .ex_valid(d2_ex_valid), .ex_ALU_op(d2_ALU_op),
        .ex_DMtoReg(d2_DMtoReg), .ex_RegWrite(d2_RegWrite), .ex_DM_en(d2_DM_en),
        .ex_DM_write(d2_DM_write), .ex_jump(d2_jump), .ex_jalr(d2_jalr),
        .ex_branch(d2_branch), .ex_ALU_src(d2_ALU_src), .ex_auipc(d2_auipc),
        .ex_muldiv(d2_muldiv), .ex_illegal(d2_illegal), .ex_rd(d2_rd), .ex_busy(d2_busy)
    );

    function automatic logic [13:0] ref_word(input logic [6:0] o, input logic f7);
        case (o)
            OP_R:     return f7 ? W_MUL : W_R;
            OP_I:     return W_I;
            OP_LW:    return W_LW;
            OP_S:     return W_S;
            OP_B:     return W_B;
            OP_LUI:   return W_LUI;
            OP_JAL:   return W_JAL;
            OP_JALR:  return W_JALR;
            OP_AUIPC: return W_AUIPC;
            default:  return W_ILL;
        endcase
    endfunction

    function automatic bit reads_rs1(input logic [6:0] o);
        return o inside {OP_R, OP_I, OP_LW, OP_S, OP_B, OP_JALR};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] o);
        return o inside {OP_R, OP_S, OP_B};
    endfunction

    function automatic bit m_load_use();
        bit ex_is_load = m_valid && (m_word == W_LW) && (m_rd != 5'd0);
        return ex_is_load && id_valid &&
               ((reads_rs1(op) && rs1 == m_rd) || (reads_rs2(op) && rs2 == m_rd));
    endfunction

    function automatic bit m_can_advance();
        return !m_valid || (ex_ready && m_hold == 0);
    endfunction

    function automatic bit m_id_ready();
        if (rst) return 1'b0;
        return flush || (m_can_advance() && id_valid && !m_load_use());
    endfunction

    // Advance the model by one clock with the current inputs, then move to the next negedge.
    task automatic tick();
        if (rst) begin
            m_valid = 0; m_word = W_DEF; m_rd = 0; m_hold = 0;
        end else if (m_can_advance()) begin
            if (flush || m_load_use() || !id_valid) begin
                m_valid = 0; m_word = W_DEF; m_rd = 0; m_hold = 0;
            end else begin
                m_valid = 1; m_word = ref_word(op, funct7_0); m_rd = rd;
                m_hold  = (m_word == W_MUL) ? MUL_LAT - 1 : 0;
            end
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic present(input logic [6:0] o, input logic f7, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] d);
        id_valid = 1'b1; op = o; funct7_0 = f7; rs1 = s1; rs2 = s2; rd = d;
        #1;
    endtask

    task automatic drain();
        id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        repeat (MUL_LAT + 1) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; id_valid = 1'b1; flush = 1'b1; op = OP_R;
        tick();
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready got %b want 0", id_ready); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %b want 0", ex_valid); end
        checks++; if (ex_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ex_busy); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", ex_rd); end
        checks++; if (dut_word !== W_DEF) begin errors++; $display("FAIL reset_word got %b want %b", dut_word, W_DEF); end
        rst = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        #1;
    endtask

    task automatic test_rtype();
        present(OP_R, 1'b0, 5'd1, 5'd2, 5'd5);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL rtype_accept got %b want 1", id_ready); end
        tick();
        id_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rtype_valid got %b want 1", ex_valid); end
        checks++; if (dut_word !== W_R) begin errors++; $display("FAIL rtype_word got %b want %b", dut_word, W_R); end
        checks++; if (ex_rd !== 5'd5) begin errors++; $display("FAIL rtype_rd got %0d want 5", ex_rd); end
        drain();
    endtask

    task automatic test_load_use();
        present(OP_LW, 1'b0, 5'd1, 5'd0, 5'd3);
        tick();
        present(OP_R, 1'b0, 5'd3, 5'd4, 5'd6);
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall got %b want 0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b want 0", ex_valid); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_retry got %b want 1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || dut_word !== W_R || ex_rd !== 5'd6) begin
            errors++; $display("FAIL lu_add_in_ex got v=%b w=%b rd=%0d want v=1 w=%b rd=6", ex_valid, dut_word, ex_rd, W_R);
        end
        present(OP_LW, 1'b0, 5'd1, 5'd0, 5'd0);
        tick();
        present(OP_R, 1'b0, 5'd0, 5'd0, 5'd7);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_rd0_nostall got %b want 1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || dut_word !== W_R) begin
            errors++; $display("FAIL lu_rd0_ex got v=%b w=%b want v=1 w=%b", ex_valid, dut_word, W_R);
        end
        drain();
    endtask

    task automatic test_muldiv();
        present(OP_R, 1'b1, 5'd1, 5'd2, 5'd7);
        tick();
        present(OP_R, 1'b0, 5'd1, 5'd2, 5'd8);
        checks++; if (d2_illegal !== 1'b1 || d2_RegWrite !== 1'b0 || d2_busy !== 1'b0 || d2_ex_valid !== 1'b1) begin
            errors++; $display("FAIL nomd_illegal got ill=%b rw=%b busy=%b v=%b want 1 0 0 1", d2_illegal, d2_RegWrite, d2_busy, d2_ex_valid);
        end
        for (int c = 1; c <= MUL_LAT; c++) begin
            checks++; if (ex_valid !== 1'b1 || ex_muldiv !== 1'b1 || ex_rd !== 5'd7) begin
                errors++; $display("FAIL mul_hold c=%0d got v=%b md=%b rd=%0d want 1 1 7", c, ex_valid, ex_muldiv, ex_rd);
            end
            checks++; if (ex_busy !== (c < MUL_LAT)) begin
                errors++; $display("FAIL mul_busy c=%0d got %b want %b", c, ex_busy, c < MUL_LAT);
            end
            checks++; if (id_ready !== (c == MUL_LAT)) begin
                errors++; $display("FAIL mul_id_ready c=%0d got %b want %b", c, id_ready, c == MUL_LAT);
            end
            tick();
        end
        checks++; if (ex_valid !== 1'b1 || ex_muldiv !== 1'b0 || ex_rd !== 5'd8) begin
            errors++; $display("FAIL mul_next got v=%b md=%b rd=%0d want 1 0 8", ex_valid, ex_muldiv, ex_rd);
        end
        drain();
    endtask

    task automatic test_decode();
        logic [6:0]  ops [9]  = '{7'b1111111, OP_JALR, OP_AUIPC, OP_I, OP_LW, OP_S, OP_B, OP_LUI, OP_JAL};
        logic [13:0] want [9] = '{W_ILL, W_JALR, W_AUIPC, W_I, W_LW, W_S, W_B, W_LUI, W_JAL};
        for (int k = 0; k < 9; k++) begin
            present(ops[k], 1'b0, 5'd0, 5'd0, 5'd9);
            tick();
            checks++; if (ex_valid !== 1'b1 || dut_word !== want[k]) begin
                errors++; $display("FAIL decode op=%b got v=%b w=%b want v=1 w=%b", ops[k], ex_valid, dut_word, want[k]);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        present(OP_LW, 1'b0, 5'd1, 5'd0, 5'd3);
        tick();
        present(OP_R, 1'b0, 5'd3, 5'd3, 5'd4);
        flush = 1'b1; #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_hazard_ready got %b want 1", id_ready); end
        tick();
        flush = 1'b0; id_valid = 1'b0; #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble got %b want 0", ex_valid); end
        present(OP_R, 1'b1, 5'd1, 5'd2, 5'd7);
        tick();
        present(OP_I, 1'b0, 5'd1, 5'd0, 5'd2);
        flush = 1'b1; #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_during_mul got %b want 1", id_ready); end
        tick();
        flush = 1'b0; id_valid = 1'b0; #1;
        checks++; if (ex_valid !== 1'b1 || ex_muldiv !== 1'b1 || ex_rd !== 5'd7) begin
            errors++; $display("FAIL flush_mul_held got v=%b md=%b rd=%0d want 1 1 7", ex_valid, ex_muldiv, ex_rd);
        end
        drain();
    endtask

    task automatic test_reset_mid_mul();
        present(OP_R, 1'b1, 5'd1, 5'd2, 5'd7);
        tick();
        id_valid = 1'b0;
        tick();
        rst = 1'b1; #1;
        tick();
        rst = 1'b0; #1;
        checks++; if (ex_valid !== 1'b0 || ex_busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_mul got v=%b busy=%b want 0 0", ex_valid, ex_busy);
        end
        drain();
    endtask

    task automatic test_random();
        logic [6:0] pool [11] = '{OP_R, OP_R, OP_I, OP_LW, OP_LW, OP_S, OP_B, OP_LUI, OP_JAL, OP_JALR, OP_AUIPC};
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(99) < 2);
            id_valid = ($urandom_range(99) < 80);
            flush    = ($urandom_range(99) < 10);
            ex_ready = ($urandom_range(99) < 75);
            op       = ($urandom_range(19) == 0) ? 7'($urandom) : pool[$urandom_range(10)];
            funct7_0 = ($urandom_range(3) == 0);
            rs1      = 5'($urandom_range(3));
            rs2      = 5'($urandom_range(3));
            rd       = 5'($urandom_range(3));
            #1;
            checks++; if (id_ready !== m_id_ready()) begin
                errors++; $display("FAIL rand_id_ready n=%0d got %b want %b", n, id_ready, m_id_ready());
            end
            checks++; if (ex_valid !== m_valid || dut_word !== m_word || ex_busy !== (m_hold > 0)) begin
                errors++; $display("FAIL rand_ex n=%0d got v=%b w=%b busy=%b want v=%b w=%b busy=%b",
                                   n, ex_valid, dut_word, ex_busy, m_valid, m_word, m_hold > 0);
            end
            if (m_valid) begin
                checks++; if (ex_rd !== m_rd) begin
                    errors++; $display("FAIL rand_rd n=%0d got %0d want %0d", n, ex_rd, m_rd);
                end
            end
            tick();
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        op = 7'd0; funct7_0 = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        m_valid = 0; m_word = W_DEF; m_rd = 0; m_hold = 0;
        @(negedge clk);
        #1;
        test_reset();
        test_rtype();
        test_load_use();
        test_muldiv();
        test_decode();
        test_flush();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
